speech_sequencer: RTL and testbench



---
 rtl/speech_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_speech_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speech_sequencer.sv
// speech_sequencer
//   Plays one phrase per start request. The phrase lives in the shared
//   phrase memory at a 32-byte-aligned base address. Bytes are fetched one
//   at a time over a req/gnt/valid port and streamed to the character output
//   stage over a valid/ready handshake. A 0x00 byte terminates the phrase
//   early. Each phrase is followed by a cooldown. A memory read that never
//   returns data aborts the phrase with an error pulse.
//
// Ports
//   clk          system clock
//   nrst         asynchronous active-low reset
//   start        speak the phrase at phrase_addr (sampled only when idle)
//   phrase_addr  phrase base address, bits [4:0] ignored
//   mem_req      memory access request
//   mem_addr     byte address {base, idx}, valid while mem_req=1
//   mem_gnt      arbiter grant (one cycle, only while mem_req=1)
//   mem_valid    read data valid (one cycle)
//   mem_data     read data, qualified by mem_valid
//   char_data    phrase byte for the output stage
//   char_valid   char_data valid
//   char_ready   output stage accepts when char_valid & char_ready
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse at normal phrase end
//   error        one-cycle pulse on timeout abort
module speech_sequencer #(
    parameter int unsigned COOLDOWN_CYCLES = 32'd64,
    parameter int unsigned TIMEOUT_CYCLES  = 32'd255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] phrase_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Counter widths carry one spare bit so the "one" constants below can be
    // built by replication for every legal parameter value.
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 32'd1) + 32'd1;
    localparam int unsigned COOL_B = $clog2(COOLDOWN_CYCLES + 32'd1);
    localparam int unsigned COOL_W = ((COOL_B < 32'd1) ? 32'd1 : COOL_B) + 32'd1;

    localparam logic [TMR_W-1:0]  TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [COOL_W-1:0] COOL_ONE  = {{(COOL_W-1){1'b0}}, 1'b1};
    // Abort happens in the WAIT cycle whose timer value is TIMEOUT_CYCLES-1,
    // i.e. after exactly TIMEOUT_CYCLES wait cycles without data.
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [COOL_W-1:0] COOL_LAST =
        COOL_W'((COOLDOWN_CYCLES > 32'd0) ? (COOLDOWN_CYCLES - 32'd1) : 32'd0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_END  = 3'd4,
        ST_COOL = 3'd5
    } state_t;

    // Folds the ignored low address bits so they are consumed deliberately.
    function automatic logic parity5(input logic [4:0] v);
        return ^v;
    endfunction

    state_t              state_r;
    logic [10:0]         base_r;
    logic [4:0]          idx_r;
    logic [TMR_W-1:0]    timer_r;
    logic [COOL_W-1:0]   cool_cnt_r;
    logic                mem_req_r;
    logic [7:0]          char_data_r;
    logic                char_valid_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                unused_addr_bits_s;

    assign unused_addr_bits_s = parity5(phrase_addr[4:0]);

    assign mem_req    = mem_req_r;
    assign mem_addr   = {base_r, idx_r};
    assign char_data  = char_data_r;
    assign char_valid = char_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

    // Phrase sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= ST_IDLE;
            base_r       <= 11'd0;
            idx_r        <= 5'd0;
            timer_r      <= '0;
            cool_cnt_r   <= '0;
            mem_req_r    <= 1'b0;
            char_data_r  <= 8'h00;
            char_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            // done and error are single-cycle pulses.
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_r    <= phrase_addr[15:5];
                        idx_r     <= 5'd0;
                        mem_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Grant wait is unbounded: the arbiter may serve others.
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        timer_r   <= '0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Data arriving in the timeout cycle still wins.
                    if (mem_valid) begin
                        if (mem_data == 8'h00) begin
                            done_r  <= 1'b1;
                            state_r <= ST_END;
                        end else begin
                            char_data_r  <= mem_data;
                            char_valid_r <= 1'b1;
                            state_r      <= ST_EMIT;
                        end
                    end else if (timer_r == TMR_LAST) begin
                        error_r <= 1'b1;
                        if (COOLDOWN_CYCLES == 32'd0) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            cool_cnt_r <= '0;
                            state_r    <= ST_COOL;
                        end
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                ST_EMIT: begin
                    if (char_ready) begin
                        char_valid_r <= 1'b0;
                        // Byte 31 is the last slot; idx never wraps.
                        if (idx_r == 5'd31) begin
                            done_r  <= 1'b1;
                            state_r <= ST_END;
                        end else begin
                            idx_r     <= idx_r + 5'd1;
                            mem_req_r <= 1'b1;
                            state_r   <= ST_REQ;
                        end
                    end
                end
                ST_END: begin
                    if (COOLDOWN_CYCLES == 32'd0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cool_cnt_r <= '0;
                        state_r    <= ST_COOL;
                    end
                end
                ST_COOL: begin
                    if (cool_cnt_r == COOL_LAST) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cool_cnt_r <= cool_cnt_r + COOL_ONE;
                    end
                end
                default: begin
                    mem_req_r    <= 1'b0;
                    char_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speech_sequencer.sv
// Directed testbench for speech_sequencer. A cycle-stepped memory and
// output-stage responder (run_phrase) drives inputs on the falling edge and
// records what the DUT did; each test task compares those records against
// hand-computed values. DUT built with COOLDOWN_CYCLES=64, TIMEOUT_CYCLES=4.
module tb_speech_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] phrase_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [7:0]  mem_data;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_img [32];
    logic [15:0] fetch_q [$];
    logic [7:0]  emit_q  [$];
    int done_cnt, err_cnt, done_cyc, err_cyc, end_cyc, last_gnt_cyc;
    int busy_after_done, addr_unstable, char_unstable, stall_valid_cycles;
    int req_hold_first;
    bit timed_out;

    speech_sequencer #(
        .COOLDOWN_CYCLES(32'd64),
        .TIMEOUT_CYCLES (32'd4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .phrase_addr(phrase_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Steps the DUT one cycle at a time after a start has been latched,
    // playing memory (grant after gnt_delay request cycles, data one cycle
    // after grant) and output stage (optional stall on one byte).
    task automatic run_phrase(input int gnt_delay, input int stall_idx, input int stall_len,
                              input bit no_valid, input int inj_cycle,
                              input logic [15:0] inj_addr, input bit abort_emit);
        int req_cnt = 0;
        int stall_cnt = 0;
        bit pend = 1'b0;
        logic [7:0] pend_data = 8'h00;
        logic [15:0] req_addr = 16'h0000;
        logic [7:0] held_data = 8'h00;
        bit held_v = 1'b0;
        bit seen_busy = 1'b0;
        bit seen_done = 1'b0;
        bit finished = 1'b0;
        fetch_q.delete();
        emit_q.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; end_cyc = -1;
        last_gnt_cyc = -1; busy_after_done = 0; addr_unstable = 0; char_unstable = 0;
        stall_valid_cycles = 0; req_hold_first = 0; timed_out = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (abort_emit && char_valid) begin
                nrst = 1'b0;
                mem_gnt = 1'b0; mem_valid = 1'b0; start = 1'b0;
                return;
            end
            // Read data phase: answers the grant issued last cycle.
            if (pend) begin
                mem_valid = !no_valid;
                mem_data  = pend_data;
                pend      = 1'b0;
            end else begin
                mem_valid = 1'b0;
                mem_data  = 8'hA5;
            end
            // Request phase.
            if (mem_req) begin
                if (req_cnt == 0) req_addr = mem_addr;
                else if (mem_addr !== req_addr) addr_unstable++;
                if (req_cnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    fetch_q.push_back(mem_addr);
                    if (fetch_q.size() == 1) req_hold_first = req_cnt + 1;
                    pend = 1'b1;
                    pend_data = mem_img[mem_addr[4:0]];
                    last_gnt_cyc = cyc;
                    req_cnt = 0;
                end else begin
                    mem_gnt = 1'b0;
                    req_cnt++;
                end
            end else begin
                mem_gnt = 1'b0;
                req_cnt = 0;
            end
            // Output stage.
            if (char_valid) begin
                if (held_v && char_data !== held_data) char_unstable++;
                held_v = 1'b1;
                held_data = char_data;
                if (emit_q.size() == stall_idx) stall_valid_cycles++;
                if (emit_q.size() == stall_idx && stall_cnt < stall_len) begin
                    char_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    char_ready = 1'b1;
                    emit_q.push_back(char_data);
                    held_v = 1'b0;
                end
            end else begin
                char_ready = 1'b1;
                held_v = 1'b0;
            end
            // Status pulses.
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                seen_done = 1'b1;
            end else if (seen_done && busy) begin
                busy_after_done++;
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            start = (cyc == inj_cycle);
            if (cyc == inj_cycle) phrase_addr = inj_addr;
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) begin
                end_cyc = cyc;
                finished = 1'b1;
                break;
            end
        end
        mem_gnt = 1'b0;
        mem_valid = 1'b0;
        if (!finished) timed_out = 1'b1;
    endtask

    task automatic load_hi();
        for (int i = 0; i < 32; i++) mem_img[i] = 8'h55;
        mem_img[0] = 8'h48;
        mem_img[1] = 8'h49;
        mem_img[2] = 8'h00;
    endtask

    task automatic kick(input logic [15:0] addr);
        @(negedge clk);
        phrase_addr = addr;
        start = 1'b1;
    endtask

    task automatic test_reset();
        bit req_seen = 1'b0;
        nrst = 1'b0; start = 1'b0; phrase_addr = 16'h0000; mem_gnt = 1'b0;
        mem_valid = 1'b0; mem_data = 8'h00; char_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, char_valid, busy, done, error} !== 5'b0 || char_data !== 8'h00 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b cv=%b busy=%b done=%b err=%b cd=%h ma=%h expected all 0",
                     mem_req, char_valid, busy, done, error, char_data, mem_addr);
        end
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0 || busy !== 1'b0) req_seen = 1'b1;
        end
        checks++;
        if (req_seen) begin
            errors++;
            $display("FAIL idle_no_start: got activity=%b expected 0", req_seen);
        end
    endtask

    task automatic test_normal_phrase();
        load_hi();
        kick(16'h0A65);
        run_phrase(0, -1, 0, 1'b0, -1, 16'h0000, 1'b0);
        checks++;
        if (fetch_q.size() != 3 || fetch_q[0] !== 16'h0A60 || fetch_q[1] !== 16'h0A61 || fetch_q[2] !== 16'h0A62) begin
            errors++;
            $display("FAIL normal_fetch_addr: got n=%0d %h %h %h expected 3 0a60 0a61 0a62",
                     fetch_q.size(), fetch_q[0], fetch_q[1], fetch_q[2]);
        end
        checks++;
        if (emit_q.size() != 2 || emit_q[0] !== 8'h48 || emit_q[1] !== 8'h49) begin
            errors++;
            $display("FAIL normal_chars: got n=%0d %h %h expected 2 48 49", emit_q.size(), emit_q[0], emit_q[1]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 9 || err_cnt != 0) begin
            errors++;
            $display("FAIL normal_done: got cnt=%0d cyc=%0d err=%0d expected 1 9 0", done_cnt, done_cyc, err_cnt);
        end
        checks++;
        if (busy_after_done != 64 || end_cyc != 74 || timed_out) begin
            errors++;
            $display("FAIL normal_cooldown: got busy=%0d end=%0d to=%b expected 64 74 0",
                     busy_after_done, end_cyc, timed_out);
        end
    endtask

    task automatic test_full_phrase();
        for (int i = 0; i < 32; i++) mem_img[i] = 8'(8'h41 + i);
        kick(16'h1234);
        run_phrase(0, -1, 0, 1'b0, -1, 16'h0000, 1'b0);
        checks++;
        if (fetch_q.size() != 32 || fetch_q[0] !== 16'h1220 || fetch_q[31] !== 16'h123F) begin
            errors++;
            $display("FAIL full_fetch: got n=%0d first=%h last=%h expected 32 1220 123f",
                     fetch_q.size(), fetch_q[0], fetch_q[31]);
        end
        checks++;
        if (emit_q.size() != 32 || emit_q[0] !== 8'h41 || emit_q[31] !== 8'h60) begin
            errors++;
            $display("FAIL full_chars: got n=%0d first=%h last=%h expected 32 41 60",
                     emit_q.size(), emit_q[0], emit_q[31]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 97 || timed_out) begin
            errors++;
            $display("FAIL full_done: got cnt=%0d cyc=%0d to=%b expected 1 97 0", done_cnt, done_cyc, timed_out);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 32; i++) mem_img[i] = 8'h00;
        mem_img[0] = 8'h41; mem_img[1] = 8'h42; mem_img[2] = 8'h43; mem_img[3] = 8'h44;
        kick(16'h2040);
        run_phrase(10, 2, 5, 1'b0, -1, 16'h0000, 1'b0);
        checks++;
        if (emit_q.size() != 4 || emit_q[0] !== 8'h41 || emit_q[1] !== 8'h42 || emit_q[2] !== 8'h43 || emit_q[3] !== 8'h44) begin
            errors++;
            $display("FAIL bp_chars: got n=%0d %h %h %h %h expected 4 41 42 43 44",
                     emit_q.size(), emit_q[0], emit_q[1], emit_q[2], emit_q[3]);
        end
        checks++;
        if (stall_valid_cycles != 6 || char_unstable != 0) begin
            errors++;
            $display("FAIL bp_stall: got valid_cycles=%0d unstable=%0d expected 6 0", stall_valid_cycles, char_unstable);
        end
        checks++;
        if (req_hold_first != 11 || addr_unstable != 0 || fetch_q.size() != 5) begin
            errors++;
            $display("FAIL bp_req_hold: got hold=%0d unstable=%0d fetches=%0d expected 11 0 5",
                     req_hold_first, addr_unstable, fetch_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || timed_out) begin
            errors++;
            $display("FAIL bp_done: got done=%0d err=%0d to=%b expected 1 0 0", done_cnt, err_cnt, timed_out);
        end
    endtask

    task automatic test_ignored_start();
        load_hi();
        kick(16'h0A65);
        run_phrase(0, -1, 0, 1'b0, 4, 16'hBEEF, 1'b0);
        checks++;
        if (fetch_q.size() != 3 || fetch_q[1] !== 16'h0A61 || fetch_q[2] !== 16'h0A62) begin
            errors++;
            $display("FAIL ignored_start_addr: got n=%0d %h %h expected 3 0a61 0a62",
                     fetch_q.size(), fetch_q[1], fetch_q[2]);
        end
        checks++;
        if (emit_q.size() != 2 || emit_q[1] !== 8'h49 || done_cyc != 9) begin
            errors++;
            $display("FAIL ignored_start_chars: got n=%0d %h done_cyc=%0d expected 2 49 9",
                     emit_q.size(), emit_q[1], done_cyc);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_queued: got req=%b busy=%b expected 0 0", mem_req, busy);
        end
    endtask

    task automatic test_timeout();
        load_hi();
        kick(16'h3300);
        run_phrase(0, -1, 0, 1'b1, 20, 16'h4400, 1'b0);
        checks++;
        if (err_cnt != 1 || done_cnt != 0 || err_cyc != 6 || last_gnt_cyc != 1) begin
            errors++;
            $display("FAIL timeout_error: got err=%0d done=%0d err_cyc=%0d gnt_cyc=%0d expected 1 0 6 1",
                     err_cnt, done_cnt, err_cyc, last_gnt_cyc);
        end
        checks++;
        if (fetch_q.size() != 1 || emit_q.size() != 0 || end_cyc != 70) begin
            errors++;
            $display("FAIL timeout_cool: got fetches=%0d chars=%0d end=%0d expected 1 0 70",
                     fetch_q.size(), emit_q.size(), end_cyc);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_start_in_cool: got req=%b busy=%b expected 0 0", mem_req, busy);
        end
        phrase_addr = 16'h7777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h7760) begin
            errors++;
            $display("FAIL timeout_restart: got req=%b addr=%h expected 1 7760", mem_req, mem_addr);
        end
        run_phrase(0, -1, 0, 1'b0, -1, 16'h0000, 1'b0);
        checks++;
        if (emit_q.size() != 2 || done_cnt != 1 || timed_out) begin
            errors++;
            $display("FAIL timeout_next_phrase: got chars=%0d done=%0d to=%b expected 2 1 0",
                     emit_q.size(), done_cnt, timed_out);
        end
    endtask

    task automatic test_reset_abort();
        load_hi();
        kick(16'h0A65);
        run_phrase(0, -1, 0, 1'b0, -1, 16'h0000, 1'b1);
        #1;
        checks++;
        if ({mem_req, char_valid, busy, done, error} !== 5'b0 || char_data !== 8'h00) begin
            errors++;
            $display("FAIL abort_outputs: got req=%b cv=%b busy=%b done=%b err=%b cd=%h expected all 0",
                     mem_req, char_valid, busy, done, error, char_data);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, char_valid, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL abort_after_release: got req=%b cv=%b busy=%b done=%b err=%b expected all 0",
                     mem_req, char_valid, busy, done, error);
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_normal_phrase();
        test_full_phrase();
        test_backpressure();
        test_ignored_start();
        test_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
